reg_write_port: RTL and testbench

// - Write side of the 16x16 register bank; counterpart of the 16:1 read-select path.
// - Accepts write-back requests (select + data) over a valid/ready handshake.
// - Decodes the 4-bit select to a one-hot enable and commits data to one of 16 registers.
// - Exposes every register flat for the read mux, plus the in-flight write for bypass.

---
 rtl/core_pkg.sv | 31 +++
 rtl/reg_write_port_if.sv | 15 +
 rtl/reg_sel_decoder.sv | 18 +
 rtl/reg_write_port.sv | 87 ++++++++
 tb/tb_reg_write_port.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared register-bank constants: widths, select width and the register index names
// used by both the write port and the read mux.
package core_pkg;

  localparam int DATA_W    = 16;
  localparam int NREG      = 16;
  localparam int REG_SEL_W = 4;

  localparam logic [REG_SEL_W-1:0] R0  = 4'd0;
  localparam logic [REG_SEL_W-1:0] R1  = 4'd1;
  localparam logic [REG_SEL_W-1:0] R2  = 4'd2;
  localparam logic [REG_SEL_W-1:0] R3  = 4'd3;
  localparam logic [REG_SEL_W-1:0] R4  = 4'd4;
  localparam logic [REG_SEL_W-1:0] R5  = 4'd5;
  localparam logic [REG_SEL_W-1:0] R6  = 4'd6;
  localparam logic [REG_SEL_W-1:0] R7  = 4'd7;
  localparam logic [REG_SEL_W-1:0] R8  = 4'd8;
  localparam logic [REG_SEL_W-1:0] R9  = 4'd9;
  localparam logic [REG_SEL_W-1:0] R10 = 4'd10;
  localparam logic [REG_SEL_W-1:0] R11 = 4'd11;
  localparam logic [REG_SEL_W-1:0] R12 = 4'd12;
  localparam logic [REG_SEL_W-1:0] R13 = 4'd13;
  localparam logic [REG_SEL_W-1:0] R14 = 4'd14;
  localparam logic [REG_SEL_W-1:0] R15 = 4'd15;

  // True when a write targets the hard-wired zero register (only meaningful if enabled).
  function automatic logic is_zero_sel(input logic zero_en, input logic [REG_SEL_W-1:0] sel);
    return zero_en && (sel == R0);
  endfunction

endpackage

// File: rtl/reg_write_port_if.sv
// Write-back request channel: select + data over a valid/ready handshake.
interface reg_write_port_if #(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int SEL_W  = core_pkg::REG_SEL_W
);

  logic              wr_valid;
  logic              wr_ready;
  logic [SEL_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_sel, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_sel, input wr_data, output wr_ready);

endinterface

// File: rtl/reg_sel_decoder.sv
// Combinational select-to-one-hot decoder; all outputs low when i_en is low.
module reg_sel_decoder #(
  parameter int NREG  = 16,
  parameter int SEL_W = 4
) (
  input  logic [SEL_W-1:0] i_sel,
  input  logic             i_en,
  output logic [NREG-1:0]  o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < NREG; i++) begin
      o_onehot[i] = i_en && (i_sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/reg_write_port.sv
// Write side of the register bank: one-deep pending stage (S1) feeding a bank of
// enabled registers, with the pending write exposed for read-path bypass.
module reg_write_port #(
  parameter int DATA_W      = core_pkg::DATA_W,
  parameter int NREG        = core_pkg::NREG,
  parameter bit ZERO_REG_EN = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_write_port_if.slave        wr,
  input  logic                   hold,
  output logic [NREG*DATA_W-1:0] regs_flat,
  output logic                   pend_valid,
  output logic [3:0]             pend_sel,
  output logic [DATA_W-1:0]      pend_data,
  output logic                   wr_done
);

  import core_pkg::*;

  logic                 r_live;
  logic                 r_pend_vis;
  logic [REG_SEL_W-1:0] r_sel;
  logic [DATA_W-1:0]    r_data;
  logic                 r_done;
  logic                 w_commit;
  logic                 w_accept;
  logic                 w_zero_hit;
  logic [NREG-1:0]      w_en;

  // r_live tracks a real pending write; a zero-register write is live (so it still
  // commits and pulses wr_done) but never shown on pend_valid.
  assign wr.wr_ready = !r_live || !hold;
  assign w_accept    = wr.wr_valid && wr.wr_ready;
  assign w_commit    = r_live && !hold;
  assign w_zero_hit  = is_zero_sel(ZERO_REG_EN, r_sel);

  // S1: pending register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_live     <= 1'b0;
      r_pend_vis <= 1'b0;
      r_sel      <= '0;
      r_data     <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_accept) begin
        r_live     <= 1'b1;
        r_pend_vis <= !is_zero_sel(ZERO_REG_EN, wr.wr_sel);
        r_sel      <= wr.wr_sel;
        r_data     <= wr.wr_data;
      end else if (w_commit) begin
        r_live     <= 1'b0;
        r_pend_vis <= 1'b0;
      end
    end
  end

  reg_sel_decoder #(
    .NREG  (NREG),
    .SEL_W (REG_SEL_W)
  ) u_dec (
    .i_sel    (r_sel),
    .i_en     (w_commit && !w_zero_hit),
    .o_onehot (w_en)
  );

  // Commit stage: register bank
  for (genvar g = 0; g < NREG; g++) begin : g_reg
    logic [DATA_W-1:0] r_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_q <= '0;
      end else if (w_en[g]) begin
        r_q <= r_data;
      end
    end
    assign regs_flat[g*DATA_W +: DATA_W] = r_q;
  end

  assign pend_valid = r_pend_vis;
  assign pend_sel   = r_sel;
  assign pend_data  = r_data;
  assign wr_done    = r_done;

endmodule

// File: tb/tb_reg_write_port.sv
// Self-checking bench for reg_write_port: directed scenarios plus random traffic
// compared against a transaction-level model of the bank and its pending slot.
module tb_reg_write_port;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         hold0, hold1;
  logic [255:0] rf0, rf1;
  logic         pv0, pv1, done0, done1;
  logic [3:0]   ps0, ps1;
  logic [15:0]  pd0, pd1;

  int checks = 0;
  int errors = 0;

  // Model: register contents and the single pending write per DUT (1 = zero-reg variant).
  logic [15:0] m_regs [2][16];
  bit          m_pv   [2];
  logic [3:0]  m_sel  [2];
  logic [15:0] m_data [2];
  bit          m_done [2];

  always #5 clk = ~clk;

  reg_write_port_if #(.DATA_W(16), .SEL_W(4)) if0 ();
  reg_write_port_if #(.DATA_W(16), .SEL_W(4)) if1 ();

  reg_write_port #(.DATA_W(16), .NREG(16), .ZERO_REG_EN(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .wr(if0), .hold(hold0), .regs_flat(rf0),
    .pend_valid(pv0), .pend_sel(ps0), .pend_data(pd0), .wr_done(done0)
  );

  reg_write_port #(.DATA_W(16), .NREG(16), .ZERO_REG_EN(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .wr(if1), .hold(hold1), .regs_flat(rf1),
    .pend_valid(pv1), .pend_sel(ps1), .pend_data(pd1), .wr_done(done1)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) m_regs[d][i] = '0;
      m_pv[d] = 0; m_sel[d] = '0; m_data[d] = '0; m_done[d] = 0;
    end
  endtask

  task automatic model_tick(input int d, input bit v, input logic [3:0] s,
                            input logic [15:0] dt, input bit h);
    bit commit, accept;
    commit = m_pv[d] && !h;
    accept = v && (!m_pv[d] || !h);
    m_done[d] = commit;
    if (commit && !(d == 1 && m_sel[d] == 4'd0)) m_regs[d][m_sel[d]] = m_data[d];
    if (accept) begin
      m_pv[d] = 1; m_sel[d] = s; m_data[d] = dt;
    end else if (commit) begin
      m_pv[d] = 0;
    end
  endtask

  task automatic check_outs(input int d);
    logic [255:0] e;
    for (int i = 0; i < 16; i++) e[i*16 +: 16] = m_regs[d][i];
    chk($sformatf("regs_flat[%0d]", d), (d == 1) ? rf1 : rf0, e);
    chk($sformatf("pend_valid[%0d]", d), (d == 1) ? pv1 : pv0,
        m_pv[d] && !(d == 1 && m_sel[d] == 4'd0));
    chk($sformatf("pend_sel[%0d]", d), (d == 1) ? ps1 : ps0, m_sel[d]);
    chk($sformatf("pend_data[%0d]", d), (d == 1) ? pd1 : pd0, m_data[d]);
    chk($sformatf("wr_done[%0d]", d), (d == 1) ? done1 : done0, m_done[d]);
  endtask

  task automatic drive(input int d, input bit v, input logic [3:0] s,
                       input logic [15:0] dt, input bit h);
    if0.wr_valid = (d == 0) && v; if0.wr_sel = (d == 0) ? s : 4'd0;
    if0.wr_data = (d == 0) ? dt : 16'd0; hold0 = (d == 0) && h;
    if1.wr_valid = (d == 1) && v; if1.wr_sel = (d == 1) ? s : 4'd0;
    if1.wr_data = (d == 1) ? dt : 16'd0; hold1 = (d == 1) && h;
  endtask

  task automatic step(input int d, input bit v, input logic [3:0] s,
                      input logic [15:0] dt, input bit h);
    @(negedge clk);
    drive(d, v, s, dt, h);
    #1;
    chk($sformatf("wr_ready[%0d]", d), (d == 1) ? if1.wr_ready : if0.wr_ready,
        !m_pv[d] || !h);
    @(posedge clk);
    model_tick(d, v, s, dt, h);
    model_tick(1 - d, 1'b0, 4'd0, 16'd0, 1'b0);
    #1;
    check_outs(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1'b0, 4'd0, 16'd0, 1'b0);
    @(posedge clk);
    model_clear();
    #1;
    check_outs(0); check_outs(1);
    @(posedge clk);
    #1;
    check_outs(0); check_outs(1);
    chk("ready_after_reset0", if0.wr_ready, 1'b1);
    chk("ready_after_reset1", if1.wr_ready, 1'b1);
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 1'b0, 4'd0, 16'd0, 1'b0);
    model_clear();
    do_reset();

    // Single write to reg 3
    step(0, 1'b1, 4'd3, 16'hA5A5, 1'b0);
    step(0, 1'b0, 4'd0, 16'h0000, 1'b0);

    // Full-rate stream over every register
    for (int i = 0; i < 16; i++) step(0, 1'b1, 4'(i), 16'h1000 + 16'(i), 1'b0);
    step(0, 1'b0, 4'd0, 16'h0000, 1'b0);

    // Stall with a pending write, then release
    step(0, 1'b1, 4'd5, 16'h1234, 1'b0);
    for (int i = 0; i < 3; i++) step(0, 1'b1, 4'd6, 16'h5555, 1'b1);
    step(0, 1'b1, 4'd6, 16'h5555, 1'b0);
    step(0, 1'b0, 4'd0, 16'h0000, 1'b0);

    // Back-to-back writes to the same register
    step(0, 1'b1, 4'd7, 16'h0001, 1'b0);
    step(0, 1'b1, 4'd7, 16'h0002, 1'b0);
    step(0, 1'b0, 4'd0, 16'h0000, 1'b0);
    step(0, 1'b0, 4'd0, 16'h0000, 1'b0);

    // Reset discards a pending write
    step(0, 1'b1, 4'd9, 16'hFFFF, 1'b1);
    do_reset();
    step(0, 1'b0, 4'd0, 16'h0000, 1'b0);

    // Zero-register variant
    step(1, 1'b1, 4'd0, 16'hBEEF, 1'b0);
    step(1, 1'b1, 4'd4, 16'hCAFE, 1'b0);
    step(1, 1'b1, 4'd0, 16'h1111, 1'b1);
    step(1, 1'b0, 4'd0, 16'h0000, 1'b0);
    step(1, 1'b0, 4'd0, 16'h0000, 1'b0);

    // Random traffic on both variants
    for (int n = 0; n < 400; n++) begin
      step(n % 2, 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           16'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    step(0, 1'b0, 4'd0, 16'h0000, 1'b0);
    step(1, 1'b0, 4'd0, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
